// File: rtl/force_release_unit.sv
// Force/release override stage for a {busa,busb} bus pair.
// Host commands force, release or deposit arbitrary bit subsets; functional writes flow underneath.
module force_release_unit #(
  parameter int WA       = 4,
  parameter int WB       = 4,
  parameter bit VAR_HOLD = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          func_we,
  input  logic [WA-1:0]                 func_a,
  input  logic [WB-1:0]                 func_b,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [WA+WB-1:0]              cmd_mask,
  input  logic [WA+WB-1:0]              cmd_data,
  output logic                          cmd_done,
  output logic [WA-1:0]                 busa,
  output logic [WB-1:0]                 busb,
  output logic [WA+WB-1:0]              forced_mask,
  output logic [WA+WB-1:0]              hold_mask,
  output logic [$clog2(WA+WB+1)-1:0]    force_cnt
);
  localparam int W  = WA + WB;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] OP_FORCE   = 2'd1;
  localparam logic [1:0] OP_RELEASE = 2'd2;
  localparam logic [1:0] OP_DEPOSIT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  state_t       r_state, w_state_next;
  logic [1:0]   r_op;
  logic [W-1:0] r_mask, r_data;
  logic [W-1:0] r_fq, r_fv, r_fm, r_hm;
  logic [W-1:0] w_fq_next, w_fv_next, w_fm_next, w_hm_next;
  logic [W-1:0] w_bus;
  logic [CW-1:0] w_cnt;
  logic         w_accept;

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    cmd_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid) w_state_next = S_APPLY;
      end
      S_APPLY: w_state_next = S_DONE;
      S_DONE: begin
        cmd_done     = ~rst;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept = cmd_valid & cmd_ready;

  always_comb begin
    w_fq_next = func_we ? {func_a, func_b} : r_fq;
    w_fv_next = r_fv;
    w_fm_next = r_fm;
    w_hm_next = r_hm;
    if (r_state == S_APPLY) begin
      case (r_op)
        OP_FORCE: begin
          w_fm_next = r_fm | r_mask;
          w_fv_next = (r_fv & ~r_mask) | (r_data & r_mask);
          w_hm_next = r_hm & ~r_mask;
        end
        OP_RELEASE: begin
          w_fm_next = r_fm & ~r_mask;
          w_hm_next = r_hm | (r_mask & r_fm);
        end
        OP_DEPOSIT: begin
          // Deposit lands on top of a same-edge functional write for its own bits.
          w_fq_next = (w_fq_next & ~r_mask) | (r_data & r_mask);
          w_hm_next = r_hm & ~r_mask;
        end
        default: ;
      endcase
    end
    if (func_we || !VAR_HOLD) w_hm_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_mask  <= '0;
      r_data  <= '0;
      r_fq    <= '0;
      r_fv    <= '0;
      r_fm    <= '0;
      r_hm    <= '0;
    end else begin
      r_state <= w_state_next;
      r_fq    <= w_fq_next;
      r_fv    <= w_fv_next;
      r_fm    <= w_fm_next;
      r_hm    <= w_hm_next;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_mask <= cmd_mask;
        r_data <= cmd_data;
      end
    end
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign w_bus[gi] = (r_fm[gi] | r_hm[gi]) ? r_fv[gi] : r_fq[gi];
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < W; i++) w_cnt = w_cnt + CW'(r_fm[i]);
  end

  assign busa        = w_bus[W-1:WB];
  assign busb        = w_bus[WB-1:0];
  assign forced_mask = r_fm;
  assign hold_mask   = r_hm;
  assign force_cnt   = w_cnt;
endmodule

// File: tb/tb_force_release_unit.sv
// Bench for force_release_unit: a VAR_HOLD=1 and a VAR_HOLD=0 instance share one stimulus stream
// and are checked every cycle against a bit-vector model of the force/release rules.
module tb_force_release_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       func_we = 1'b0;
  logic [3:0] func_a = '0, func_b = '0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_mask = '0, cmd_data = '0;

  logic       ready_h, done_h, ready_n, done_n;
  logic [3:0] busa_h, busb_h, busa_n, busb_n;
  logic [7:0] fm_h, hm_h, fm_n, hm_n;
  logic [3:0] cnt_h, cnt_n;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  force_release_unit #(.WA(4), .WB(4), .VAR_HOLD(1'b1)) u_h (
    .clk(clk), .rst(rst), .func_we(func_we), .func_a(func_a), .func_b(func_b),
    .cmd_valid(cmd_valid), .cmd_ready(ready_h), .cmd_op(cmd_op), .cmd_mask(cmd_mask),
    .cmd_data(cmd_data), .cmd_done(done_h), .busa(busa_h), .busb(busb_h),
    .forced_mask(fm_h), .hold_mask(hm_h), .force_cnt(cnt_h));

  force_release_unit #(.WA(4), .WB(4), .VAR_HOLD(1'b0)) u_n (
    .clk(clk), .rst(rst), .func_we(func_we), .func_a(func_a), .func_b(func_b),
    .cmd_valid(cmd_valid), .cmd_ready(ready_n), .cmd_op(cmd_op), .cmd_mask(cmd_mask),
    .cmd_data(cmd_data), .cmd_done(done_n), .busa(busa_n), .busb(busb_n),
    .forced_mask(fm_n), .hold_mask(hm_n), .force_cnt(cnt_n));

  // Model: index 0 = holding instance, 1 = net instance. ph counts cycles since accept.
  logic [7:0] m_fq[2] = '{8'h0, 8'h0};
  logic [7:0] m_fv[2] = '{8'h0, 8'h0};
  logic [7:0] m_fm[2] = '{8'h0, 8'h0};
  logic [7:0] m_hm[2] = '{8'h0, 8'h0};
  int         ph = 0;
  logic [1:0] l_op = '0;
  logic [7:0] l_mask = '0, l_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_fq[k] = '0; m_fv[k] = '0; m_fm[k] = '0; m_hm[k] = '0;
      end
      ph = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [7:0] fq, fv, fm, hm;
        fq = func_we ? {func_a, func_b} : m_fq[k];
        fv = m_fv[k]; fm = m_fm[k]; hm = m_hm[k];
        if (ph == 1) begin
          if (l_op == 2'd1) begin
            fm = fm | l_mask; fv = (fv & ~l_mask) | (l_data & l_mask); hm = hm & ~l_mask;
          end else if (l_op == 2'd2) begin
            if (k == 0) hm = hm | (l_mask & m_fm[k]);
            fm = fm & ~l_mask;
          end else if (l_op == 2'd3) begin
            fq = (fq & ~l_mask) | (l_data & l_mask); hm = hm & ~l_mask;
          end
        end
        if (func_we) hm = '0;
        m_fq[k] = fq; m_fv[k] = fv; m_fm[k] = fm; m_hm[k] = hm;
      end
      if (ph == 1) ph = 2;
      else if (ph == 2) ph = 0;
      else if (cmd_valid) begin
        ph = 1; l_op = cmd_op; l_mask = cmd_mask; l_data = cmd_data;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int k, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] fm, input logic [7:0] hm, input logic [3:0] cnt,
                         input logic rdy, input logic dn);
    logic [7:0] sel, bus;
    string t;
    t   = (k == 0) ? "h" : "n";
    sel = m_fm[k] | m_hm[k];
    bus = (m_fv[k] & sel) | (m_fq[k] & ~sel);
    check({t, "_busa"}, 32'(a), 32'(bus[7:4]));
    check({t, "_busb"}, 32'(b), 32'(bus[3:0]));
    check({t, "_forced_mask"}, 32'(fm), 32'(m_fm[k]));
    check({t, "_hold_mask"}, 32'(hm), 32'(m_hm[k]));
    check({t, "_force_cnt"}, 32'(cnt), 32'($countones(m_fm[k])));
    check({t, "_cmd_ready"}, 32'(rdy), 32'(!rst && ph == 0));
    check({t, "_cmd_done"}, 32'(dn), 32'(!rst && ph == 2));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, busa_h, busb_h, fm_h, hm_h, cnt_h, ready_h, done_h);
      cmp_dut(1, busa_n, busb_n, fm_n, hm_n, cnt_n, ready_n, done_n);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one command from IDLE and step through accept, apply and done back to IDLE.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] mask, input logic [7:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_busa", 32'(busa_h), 0);
    check("rst_ready", 32'(ready_h), 0);
    check("rst_cnt", 32'(cnt_h), 0);
    rst = 1'b0;

    // 1: functional write
    func_we = 1'b1; func_a = 4'h5; func_b = 4'h7;
    tick();
    func_we = 1'b0;
    check("t1_busa", 32'(busa_h), 32'h5);
    check("t1_busb", 32'(busb_h), 32'h7);
    check("t1_fm", 32'(fm_h), 0);
    check("t1_cnt", 32'(cnt_h), 0);

    // 2: force everything, then functional write is masked
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_mask = 8'hFF; cmd_data = 8'hFD;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t2_busa", 32'(busa_h), 32'hF);
    check("t2_busb", 32'(busb_h), 32'hD);
    check("t2_done", 32'(done_h), 1);
    check("t2_cnt", 32'(cnt_h), 8);
    func_we = 1'b1; func_a = 4'h0; func_b = 4'h0;
    tick();
    func_we = 1'b0;
    check("t2_busa_keep", 32'(busa_h), 32'hF);
    check("t2_busb_keep", 32'(busb_h), 32'hD);

    // 3: release low nibble; hold vs net behaviour
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_mask = 8'h0F; cmd_data = 8'h00;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t3_h_busb", 32'(busb_h), 32'hD);
    check("t3_h_hold", 32'(hm_h), 32'h0F);
    check("t3_n_busb", 32'(busb_n), 32'h0);
    check("t3_n_hold", 32'(hm_n), 32'h00);
    func_we = 1'b1; func_a = 4'h0; func_b = 4'h3;
    tick();
    func_we = 1'b0;
    check("t3_h_busb_func", 32'(busb_h), 32'h3);
    check("t3_h_busa", 32'(busa_h), 32'hF);

    // 4: functional write on the same edge as a RELEASE apply
    do_cmd(2'd1, 8'h0F, 8'h0D);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_mask = 8'h0F;
    tick();
    cmd_valid = 1'b0;
    func_we = 1'b1; func_a = 4'h0; func_b = 4'h9;
    tick();
    func_we = 1'b0;
    check("t4_h_busb", 32'(busb_h), 32'h9);
    check("t4_h_hold", 32'(hm_h), 0);
    check("t4_h_cnt", 32'(cnt_h), 4);
    check("t4_n_busb", 32'(busb_n), 32'h9);
    tick();

    // 5: back-to-back commands, then reset during APPLY
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_mask = 8'h01; cmd_data = 8'h00;
    for (int i = 0; i < 9; i++) begin
      check("t5_ready", 32'(ready_h), 32'((i % 3) == 0));
      tick();
    end
    cmd_mask = 8'hFF; cmd_data = 8'hFF;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("t5_rst_busa", 32'(busa_h), 0);
    check("t5_rst_busb", 32'(busb_h), 0);
    check("t5_rst_done", 32'(done_h), 0);
    check("t5_rst_cnt", 32'(cnt_h), 0);
    rst = 1'b0;
    tick();
    check("t5_no_done", 32'(done_h), 0);

    // 6: deposit under a force, then release reveals it
    do_cmd(2'd1, 8'hF0, 8'hF0);
    do_cmd(2'd3, 8'hF0, 8'hA0);
    check("t6_n_busa_forced", 32'(busa_n), 32'hF);
    do_cmd(2'd2, 8'hF0, 8'h00);
    check("t6_n_busa_rel", 32'(busa_n), 32'hA);
    check("t6_h_busa_hold", 32'(busa_h), 32'hF);

    // Random traffic, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) < 2);
      func_we   = ($urandom_range(0, 3) == 0);
      func_a    = 4'($urandom);
      func_b    = 4'($urandom);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       cmd_mask = 8'h00;
        1:       cmd_mask = 8'hFF;
        default: cmd_mask = 8'($urandom);
      endcase
      cmd_data  = 8'($urandom);
      tick();
    end

    rst = 1'b0; cmd_valid = 1'b0; func_we = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
